// File: rtl/upe_pkg.sv
// upe_pkg: shared word width, NWORDS limit and sequencer state encoding for the upe adders.
package upe_pkg;
  localparam int UPE_WORD_W = 32;
  localparam int UPE_NWORDS_MAX = 256;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2} upe_state_e;
endpackage

// File: rtl/upe_tripleadd32.sv
// upe_tripleadd32: combinational a + b + ci1 then + c + ci2, each stage with its own carry-out.
module upe_tripleadd32
  import upe_pkg::*;
(
  input  logic [UPE_WORD_W-1:0] a,
  input  logic [UPE_WORD_W-1:0] b,
  input  logic [UPE_WORD_W-1:0] c,
  input  logic                  ci1,
  input  logic                  ci2,
  output logic [UPE_WORD_W-1:0] sum,
  output logic                  co1,
  output logic                  co2
);
  logic [UPE_WORD_W-1:0] s1;
  assign {co1, s1}  = {1'b0, a} + {1'b0, b} + {{UPE_WORD_W{1'b0}}, ci1};
  assign {co2, sum} = {1'b0, s1} + {1'b0, c} + {{UPE_WORD_W{1'b0}}, ci2};
endmodule

// File: rtl/upe_tripleadd_seq.sv
// upe_tripleadd_seq: word-serial multi-precision A+B+C with a one-word registered output stage.
module upe_tripleadd_seq
  import upe_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  carryin1,
  input  logic                  carryin2,
  input  logic [UPE_WORD_W-1:0] a_word,
  input  logic [UPE_WORD_W-1:0] b_word,
  input  logic [UPE_WORD_W-1:0] c_word,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [UPE_WORD_W-1:0] out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  carryout1,
  output logic                  carryout2,
  output logic                  busy,
  output logic                  done
);
  localparam int IW = $clog2(NWORDS + 1);
  upe_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic c1_q, c1_d, c2_q, c2_d;
  logic [UPE_WORD_W-1:0] out_word_q, out_word_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d, done_q, done_d;
  logic [UPE_WORD_W-1:0] sum;
  logic co1, co2, in_hs, out_hs, last_word;
  upe_tripleadd32 u_add (
    .a(a_word), .b(b_word), .c(c_word), .ci1(c1_q), .ci2(c2_q),
    .sum(sum), .co1(co1), .co2(co2)
  );
  assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign last_word = idx_q == IW'(NWORDS - 1);
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q && !out_hs;
    out_last_d  = out_last_q && !out_hs;
    done_d      = 1'b0;
    if (state_q == ST_IDLE && start) begin
      state_d = ST_RUN;
      c1_d    = carryin1;
      c2_d    = carryin2;
      idx_d   = '0;
    end
    if (in_hs) begin
      out_word_d  = sum;
      out_valid_d = 1'b1;
      out_last_d  = last_word;
      c1_d        = co1;
      c2_d        = co2;
      idx_d       = idx_q + IW'(1);
      state_d     = last_word ? ST_FLUSH : state_q;
    end
    if (state_q == ST_FLUSH && out_hs && out_last_q) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
    // abort wins over any same-cycle handshake and keeps the carries as they were
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      idx_d       = idx_q;
      c1_d        = c1_q;
      c2_d        = c2_q;
      out_word_d  = out_word_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end
  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign carryout1 = c1_q;
  assign carryout2 = c2_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
endmodule

// File: tb/tb_upe_tripleadd_seq.sv
// tb_upe_tripleadd_seq: scoreboard bench over three instances (NWORDS = 4, 2, 1).
module tb_upe_tripleadd_seq;
  typedef struct {
    logic [31:0] word;
    logic        last;
  } sb_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0, carryin1 = 1'b0, carryin2 = 1'b0;
  logic [31:0] a_word = '0, b_word = '0, c_word = '0;
  logic start_v [3], in_valid_v [3], out_ready_v [3];
  logic in_ready_v [3], out_valid_v [3], out_last_v [3], co1_v [3], co2_v [3], busy_v [3], done_v [3];
  logic [31:0] out_word_v [3];
  sb_t exp_q [$];
  logic [31:0] wa [4], wb [4], wc [4], ew [4];
  bit exp_co1, exp_co2, stall_en;
  int n_checks = 0, n_errors = 0, cyc = 0, stall_left = 0;
  int done_cnt [3], outs_cnt [3], last_hs_cyc [3];
  bit prev_stall [3], prev_done [3];
  logic [31:0] prev_word [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    upe_tripleadd_seq #(.NWORDS(g == 0 ? 4 : g == 1 ? 2 : 1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .abort(abort),
      .carryin1(carryin1), .carryin2(carryin2),
      .a_word(a_word), .b_word(b_word), .c_word(c_word),
      .in_valid(in_valid_v[g]), .in_ready(in_ready_v[g]),
      .out_word(out_word_v[g]), .out_valid(out_valid_v[g]), .out_ready(out_ready_v[g]),
      .out_last(out_last_v[g]), .carryout1(co1_v[g]), .carryout2(co2_v[g]),
      .busy(busy_v[g]), .done(done_v[g])
    );
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // out_ready backpressure: occasional 3-cycle low stretches on instance 0
  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) begin
      if (stall_left > 0) begin
        out_ready_v[0] = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 7) == 0) begin
        out_ready_v[0] = 1'b0;
        stall_left = 2;
      end else out_ready_v[0] = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        prev_stall[g] = 1'b0;
        prev_done[g] = 1'b0;
      end else begin
        if (prev_stall[g]) begin
          chk("hold_valid", 32'(out_valid_v[g]), 1);
          chk("hold_word", out_word_v[g], prev_word[g]);
        end
        if (out_valid_v[g] && !out_ready_v[g]) chk("stall_in_ready", 32'(in_ready_v[g]), 0);
        if (out_valid_v[g] && out_ready_v[g]) begin
          outs_cnt[g]++;
          if (exp_q.size() == 0) chk("sb_extra_word", 32'(exp_q.size()), 1);
          else begin
            sb_t e;
            e = exp_q.pop_front();
            chk("out_word", out_word_v[g], e.word);
            chk("out_last", 32'(out_last_v[g]), 32'(e.last));
            if (out_last_v[g]) last_hs_cyc[g] = cyc;
          end
        end
        if (done_v[g]) begin
          done_cnt[g]++;
          chk("done_after_last", 32'(cyc - last_hs_cyc[g]), 1);
          chk("done_width", 32'(prev_done[g]), 0);
        end
        prev_stall[g] = out_valid_v[g] && !out_ready_v[g];
        prev_done[g] = done_v[g];
      end
      prev_word[g] = out_word_v[g];
    end
  end

  task automatic run_op(input int k, input int n, input bit ci1, input bit ci2,
                        input bit directed, input int abort_at);
    bit m1, m2;
    logic [32:0] s1, s2;
    sb_t e;
    int t, d0;
    m1 = ci1;
    m2 = ci2;
    d0 = done_cnt[k];
    carryin1 = ci1;
    carryin2 = ci2;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1 start_v[k] = 1'b0;
    for (int i = 0; i < n; i++) begin
      a_word = wa[i];
      b_word = wb[i];
      c_word = wc[i];
      in_valid_v[k] = 1'b1;
      abort = (i == abort_at);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready_v[k] && t < 200);
      if (!in_ready_v[k]) begin
        chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid_v[k] = 1'b0;
        abort = 1'b0;
        return;
      end
      if (i == abort_at) begin
        @(posedge clk);
        #1 abort = 1'b0;
        in_valid_v[k] = 1'b0;
        #2;
        chk("abort_out_valid", 32'(out_valid_v[k]), 0);
        chk("abort_out_last", 32'(out_last_v[k]), 0);
        chk("abort_busy", 32'(busy_v[k]), 0);
        chk("abort_in_ready", 32'(in_ready_v[k]), 0);
        chk("abort_co1", 32'(co1_v[k]), 32'(m1));
        chk("abort_co2", 32'(co2_v[k]), 32'(m2));
        chk("abort_sb_empty", 32'(exp_q.size()), 0);
        return;
      end
      s1 = {1'b0, wa[i]} + {1'b0, wb[i]} + 33'(m1);
      s2 = {1'b0, s1[31:0]} + {1'b0, wc[i]} + 33'(m2);
      m1 = s1[32];
      m2 = s2[32];
      e.word = directed ? ew[i] : s2[31:0];
      e.last = (i == n - 1);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
    end
    in_valid_v[k] = 1'b0;
    t = 0;
    while (done_cnt[k] == d0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("done_count", 32'(done_cnt[k] - d0), 1);
    chk("carryout1", 32'(co1_v[k]), 32'(directed ? exp_co1 : m1));
    chk("carryout2", 32'(co2_v[k]), 32'(directed ? exp_co2 : m2));
    chk("busy_idle", 32'(busy_v[k]), 0);
    chk("sb_drained", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int d0, o0;
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 1'b0;
      in_valid_v[g] = 1'b0;
      out_ready_v[g] = 1'b1;
      done_cnt[g] = 0;
      outs_cnt[g] = 0;
      last_hs_cyc[g] = 0;
    end
    #12;
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_word", out_word_v[g], 0);
      chk("rst_out_valid", 32'(out_valid_v[g]), 0);
      chk("rst_out_last", 32'(out_last_v[g]), 0);
      chk("rst_done", 32'(done_v[g]), 0);
      chk("rst_busy", 32'(busy_v[g]), 0);
      chk("rst_co1", 32'(co1_v[g]), 0);
      chk("rst_co2", 32'(co2_v[g]), 0);
      chk("rst_in_ready", 32'(in_ready_v[g]), 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // all-ones words: maximal carry chain through both stages
    for (int i = 0; i < 4; i++) begin
      wa[i] = '1; wb[i] = '1; wc[i] = '1; ew[i] = 32'hFFFF_FFFF;
    end
    ew[0] = 32'hFFFF_FFFD;
    exp_co1 = 1'b1;
    exp_co2 = 1'b1;
    run_op(0, 4, 1'b0, 1'b0, 1'b1, -1);
    wa[0] = 32'hFFFF_FFFF; wb[0] = 32'h1; wc[0] = 32'h0; ew[0] = 32'h1;
    wa[1] = 32'h0;         wb[1] = 32'h0; wc[1] = 32'h0; ew[1] = 32'h1;
    exp_co1 = 1'b0;
    exp_co2 = 1'b0;
    run_op(1, 2, 1'b0, 1'b1, 1'b1, -1);
    stall_en = 1'b1;
    repeat (100) begin
      for (int i = 0; i < 4; i++) begin
        wa[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        wb[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        wc[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      run_op(0, 4, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
    end
    stall_en = 1'b0;
    @(posedge clk);
    #1 out_ready_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wa[i] = $urandom; wb[i] = 32'hFFFF_FFFF; wc[i] = $urandom;
    end
    run_op(0, 4, 1'b1, 1'b0, 1'b0, 2);
    d0 = done_cnt[0];
    repeat (5) @(posedge clk);
    #1 chk("abort_no_done", 32'(done_cnt[0]), 32'(d0));
    run_op(0, 4, 1'b0, 1'b1, 1'b0, -1);
    d0 = done_cnt[2];
    o0 = outs_cnt[2];
    exp_q.push_back('{word: 32'h2143_658A, last: 1'b1});
    carryin1 = 1'b1;
    carryin2 = 1'b1;
    a_word = 32'h1234_5678;
    b_word = 32'h0F0F_0F0F;
    c_word = 32'h1;
    start_v[2] = 1'b1;
    in_valid_v[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 in_valid_v[2] = 1'b0;
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("held_start_done", 32'(done_cnt[2] - d0), 1);
    chk("held_start_words", 32'(outs_cnt[2] - o0), 1);
    chk("held_start_busy", 32'(busy_v[2]), 0);
    chk("held_start_sb", 32'(exp_q.size()), 0);
    chk("held_start_co1", 32'(co1_v[2]), 0);
    chk("held_start_co2", 32'(co2_v[2]), 0);
    d0 = done_cnt[2];
    out_ready_v[2] = 1'b0;
    carryin1 = 1'b0;
    carryin2 = 1'b0;
    a_word = 32'hFFFF_FFFF;
    b_word = 32'h1;
    c_word = 32'h5;
    start_v[2] = 1'b1;
    in_valid_v[2] = 1'b1;
    @(posedge clk);
    #1 start_v[2] = 1'b0;
    @(posedge clk);
    #1 in_valid_v[2] = 1'b0;
    #1;
    chk("flush_busy", 32'(busy_v[2]), 1);
    chk("flush_out_valid", 32'(out_valid_v[2]), 1);
    chk("flush_in_ready", 32'(in_ready_v[2]), 0);
    chk("flush_co1", 32'(co1_v[2]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_word", out_word_v[2], 0);
    chk("async_out_valid", 32'(out_valid_v[2]), 0);
    chk("async_out_last", 32'(out_last_v[2]), 0);
    chk("async_busy", 32'(busy_v[2]), 0);
    chk("async_done", 32'(done_v[2]), 0);
    chk("async_co1", 32'(co1_v[2]), 0);
    chk("async_co2", 32'(co2_v[2]), 0);
    #10 rst_n = 1'b1;
    out_ready_v[2] = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("reset_no_done", 32'(done_cnt[2]), 32'(d0));
    chk("reset_idle_busy", 32'(busy_v[2]), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/upe_tripleadd_seq.md
UPE_TRIPLEADD_SEQ -- requirements
Module: upe_tripleadd_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 32-bit words per multi-precision operation, legal range 1..256.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port start, input, 1: begin an operation; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1: cancel the current operation; synchronous.
REQ-006 SHALL have ports carryin1 and carryin2, input, 1 each: initial carries for the first and second addition stages; captured on start.
REQ-007 SHALL have ports a_word, b_word and c_word, input, 32 each: operand words, least-significant word first.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): operand-word handshake.
REQ-009 SHALL have port out_word, output, 32: sum word, a_word + b_word + c_word plus carries.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_last (output, 1): result handshake; out_last marks word NWORDS-1.
REQ-011 SHALL have ports carryout1 and carryout2, output, 1 each: final stage carries, valid when done is high.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1): busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-013 SHALL implement the states IDLE, RUN and FLUSH.
REQ-014 IDLE + start SHALL load c1 <= carryin1, c2 <= carryin2 and idx <= 0, then move to RUN; start outside IDLE SHALL be ignored.
REQ-015 SHALL drive in_ready = (state == RUN) && (!out_valid || out_ready).
REQ-016 An input handshake SHALL register out_word = a_word + b_word + c1, then + c_word + c2, in two chained 32-bit stages.
REQ-017 The same input handshake SHALL set out_valid <= 1, set out_last <= (idx == NWORDS-1), load c1/c2 with the stage carry-outs, and increment idx.
REQ-018 Latency SHALL be exactly 1 cycle from the input handshake to out_valid.
REQ-019 Full throughput SHALL be 1 word per cycle while out_ready is held high.
REQ-020 An output handshake with no simultaneous input handshake SHALL clear out_valid.
REQ-021 Simultaneous input and output handshakes SHALL replace out_word with no bubble.
REQ-022 out_word, out_valid and out_last SHALL stay stable while out_valid && !out_ready.
REQ-023 The input handshake on word NWORDS-1 SHALL move RUN to FLUSH; in_ready SHALL be 0 in FLUSH.
REQ-024 The output handshake with out_last = 1 SHALL move FLUSH to IDLE and pulse done high in the following cycle.
REQ-025 carryout1/carryout2 SHALL drive c1/c2 and hold their value until the next start.
REQ-026 NWORDS = 1 SHALL go RUN to FLUSH on the first word.
REQ-027 idx SHALL be ceil(log2(NWORDS+1)) bits wide and SHALL never wrap within an operation.
REQ-028 abort in RUN or FLUSH SHALL return to IDLE next cycle, clear out_valid and out_last, raise no done, and leave c1/c2 unchanged.
REQ-029 abort SHALL take priority over a same-cycle handshake; abort in IDLE SHALL have no effect.
REQ-030 All addition SHALL be modulo 2^32 per word; carries SHALL propagate only through c1/c2.

Reset
REQ-031 rst_n low SHALL force state IDLE and idx = 0.
REQ-032 rst_n low SHALL force out_valid = out_last = done = busy = 0.
REQ-033 rst_n low SHALL force out_word = 0 and c1 = c2 = carryout1 = carryout2 = 0.
REQ-034 Reset asserted mid-operation SHALL discard the operation with no done pulse.

Structure
REQ-035 SHALL place the state encoding (2-bit), the word width constant (32) and the NWORDS legal maximum in the shared upe package.
REQ-036 SHALL instantiate exactly one upe_tripleadd32 as the per-word combinational datapath, fed by the c1/c2 registers; all sequencing SHALL live in this module.

Verification
REQ-037 NWORDS=4, carryins 0, every word A=B=C=0xFFFFFFFF, out_ready=1 -> out words FFFFFFFD, FFFFFFFF, FFFFFFFF, FFFFFFFF; out_last on word 3; carryout1=1, carryout2=1; done one cycle after the last handshake.
REQ-038 NWORDS=2, A={0,0xFFFFFFFF}, B={0,1}, C=0, carryin2=1 -> out words 00000001, 00000001; carryout1=0, carryout2=0.
REQ-039 out_ready low for 3 cycles mid-stream -> in_ready=0, out_word held stable, and no word lost or duplicated versus the reference model over 100 random operations.
REQ-040 abort asserted in the same cycle as the word-2 input handshake -> IDLE next cycle, out_valid=0, no done, busy=0; a new start then succeeds.
REQ-041 NWORDS=1, start held high for 3 cycles -> one operation only, one out word with out_last=1, one done pulse.
REQ-042 rst_n pulsed low in FLUSH -> all outputs 0 asynchronously; no done after release.
